// File: rtl/ethernet_tx_packet_buffer_pkg.sv
// Shared types and helpers for the Ethernet TX packet buffer.
// Covers state encoding, op-size codes and byte-lane masks.
package ethernet_tx_packet_buffer_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_DONE = 2'd2
  } tx_state_e;

  localparam logic [1:0] OP_SZ_B = 2'd0;
  localparam logic [1:0] OP_SZ_H = 2'd1;
  localparam logic [1:0] OP_SZ_W = 2'd2;

  // Keep mask of the final beat from length mod 4.
  function automatic logic [3:0] keep_mask(
    input logic [1:0] rem
  );
    logic [3:0] m;
    unique case (rem)
      2'd1:    m = 4'h1;
      2'd2:    m = 4'h3;
      2'd3:    m = 4'h7;
      default: m = 4'hF;
    endcase
    return m;
  endfunction

  // Unshifted byte-lane mask for a write size.
  function automatic logic [3:0] lane_mask(
    input logic [1:0] sz
  );
    logic [3:0] m;
    unique case (sz)
      OP_SZ_B: m = 4'h1;
      OP_SZ_H: m = 4'h3;
      OP_SZ_W: m = 4'hF;
      default: m = 4'h0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ethernet_tx_packet_buffer_fifo.sv
// Two-entry FIFO used as prefetch and skid storage
// between the buffer read port and the MAC stream.
module ethernet_tx_packet_buffer_fifo #(
  parameter int width_p = 37
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_v,
  input  logic [width_p-1:0] i_data,
  output logic               o_v,
  output logic [width_p-1:0] o_data,
  input  logic               i_yumi,
  output logic [1:0]         o_count
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_cnt;

  // Payload storage needs no reset.
  always_ff @(posedge i_clk) begin
    if (i_v) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (i_v)    r_wptr <= ~r_wptr;
      if (i_yumi) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, i_v} - {1'b0, i_yumi};
    end
  end

  assign o_v     = (r_cnt != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_cnt;

endmodule

// File: rtl/ethernet_tx_packet_buffer_mem.sv
// Byte-masked frame store with one write port and a
// registered (1-cycle latency) read port.
module ethernet_tx_packet_buffer_mem #(
  parameter int els_p   = 512,
  parameter int width_p = 32,
  localparam int aw_lp  = $clog2(els_p),
  localparam int mw_lp  = width_p / 8
) (
  input  logic               i_clk,
  input  logic               i_w_v,
  input  logic [aw_lp-1:0]   i_w_addr,
  input  logic [width_p-1:0] i_w_data,
  input  logic [mw_lp-1:0]   i_w_mask,
  input  logic               i_r_v,
  input  logic [aw_lp-1:0]   i_r_addr,
  output logic [width_p-1:0] o_r_data
);

  logic [width_p-1:0] r_mem [els_p];
  logic [width_p-1:0] r_rdata;

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge i_clk) begin
    if (i_w_v) begin
      for (int b = 0; b < mw_lp; b++) begin
        if (i_w_mask[b]) begin
          r_mem[i_w_addr][8*b +: 8] <= i_w_data[8*b +: 8];
        end
      end
    end
  end

  // Registered read; output holds until the next read.
  always_ff @(posedge i_clk) begin
    if (i_r_v) begin
      r_rdata <= r_mem[i_r_addr];
    end
  end

  assign o_r_data = r_rdata;

endmodule

// File: rtl/ethernet_tx_packet_buffer.sv
// TX frame store: software fills bytes and a length, then a
// send streams the frame as keep/last beats to the MAC.
module ethernet_tx_packet_buffer
  import ethernet_tx_packet_buffer_pkg::*;
#(
  parameter int eth_mtu_p    = 2048,
  parameter int data_width_p = 32,
  localparam int size_width_lp =
    $clog2($clog2(data_width_p/8) + 1),
  localparam int packet_size_width_lp =
    $clog2(eth_mtu_p + 1),
  localparam int packet_addr_width_lp =
    $clog2(eth_mtu_p)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic packet_wvalid_i,
  input  logic [packet_addr_width_lp-1:0] packet_waddr_i,
  input  logic [data_width_p-1:0] packet_wdata_i,
  input  logic [size_width_lp-1:0] packet_wdata_size_i,
  input  logic packet_wsize_valid_i,
  input  logic [packet_size_width_lp-1:0] packet_wsize_i,
  input  logic packet_send_i,
  output logic packet_req_o,
  input  logic tx_interrupt_clear_i,
  input  logic tx_interrupt_enable_i,
  input  logic tx_interrupt_enable_v_i,
  output logic tx_interrupt_pending_o,
  output logic tx_irq_o,
  output logic [data_width_p-1:0] tx_data_o,
  output logic [data_width_p/8-1:0] tx_keep_o,
  output logic tx_last_o,
  output logic tx_v_o,
  input  logic tx_ready_and_i,
  output logic wr_error_o
);

  localparam int words_lp = eth_mtu_p / 4;
  localparam int waw_lp   = packet_addr_width_lp - 2;
  localparam int bw_lp    = waw_lp + 1;
  localparam int psw_lp   = packet_size_width_lp;
  localparam int fw_lp    = data_width_p + 5;
  localparam logic [psw_lp-1:0] mtu_lp =
    psw_lp'(eth_mtu_p);

  tx_state_e r_state;
  tx_state_e w_state_n;

  logic [psw_lp-1:0] r_len;
  logic [psw_lp:0]   w_len_ext;
  logic [bw_lp-1:0]  r_rd_idx;
  logic [bw_lp-1:0]  w_rd_idx;
  logic [bw_lp-1:0]  w_beats;
  logic              r_pend;
  logic              r_pend_last;
  logic [3:0]        r_pend_keep;
  logic              r_pending;
  logic              r_enable;
  logic              r_wr_err;

  logic              w_idle;
  logic              w_start;
  logic              w_more;
  logic              w_room;
  logic              w_rd_v;
  logic              w_rd_last;
  logic [3:0]        w_rd_keep;
  logic              w_aligned;
  logic              w_wr_ok;
  logic [3:0]        w_wmask;
  logic [data_width_p-1:0] w_wdata;
  logic [data_width_p-1:0] w_rdata;
  logic              w_fifo_v;
  logic              w_yumi;
  logic [1:0]        w_fifo_cnt;
  logic [fw_lp-1:0]  w_fifo_out;

  assign w_idle  = (r_state == TX_IDLE);
  assign w_start = w_idle & packet_send_i
                 & (r_len != '0);

  // Beats per frame: ceil(length / 4).
  assign w_len_ext = {1'b0, r_len}
                   + (psw_lp+1)'(3);
  assign w_beats   = bw_lp'(w_len_ext >> 2);

  assign w_rd_idx  = w_start ? '0 : r_rd_idx;
  assign w_rd_last = (w_rd_idx == w_beats - bw_lp'(1));
  assign w_rd_keep = w_rd_last
                   ? keep_mask(r_len[1:0]) : 4'hF;

  assign w_yumi = w_fifo_v & tx_ready_and_i;
  assign w_more = (r_state == TX_SEND)
                & (r_rd_idx < w_beats);
  // Count the read in flight so the FIFO never overflows.
  assign w_room = ({1'b0, w_fifo_cnt} + {2'b0, r_pend})
                < (3'd2 + {2'b0, w_yumi});
  assign w_rd_v = w_start | (w_more & w_room);

  // Write legality: natural alignment for the size.
  always_comb begin
    w_aligned = 1'b0;
    unique case (packet_wdata_size_i)
      OP_SZ_B: w_aligned = 1'b1;
      OP_SZ_H: w_aligned = ~packet_waddr_i[0];
      OP_SZ_W: w_aligned = (packet_waddr_i[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_wr_ok = packet_wvalid_i & w_aligned & w_idle;
  assign w_wmask = lane_mask(packet_wdata_size_i)
                << packet_waddr_i[1:0];
  assign w_wdata = packet_wdata_i
                << {packet_waddr_i[1:0], 3'b000};

  ethernet_tx_packet_buffer_mem #(
    .els_p   (words_lp),
    .width_p (data_width_p)
  ) u_mem (
    .i_clk    (clk_i),
    .i_w_v    (w_wr_ok),
    .i_w_addr (packet_waddr_i[packet_addr_width_lp-1:2]),
    .i_w_data (w_wdata),
    .i_w_mask (w_wmask),
    .i_r_v    (w_rd_v),
    .i_r_addr (w_rd_idx[waw_lp-1:0]),
    .o_r_data (w_rdata)
  );

  ethernet_tx_packet_buffer_fifo #(
    .width_p (fw_lp)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (reset_n_i),
    .i_v     (r_pend),
    .i_data  ({r_pend_last, r_pend_keep, w_rdata}),
    .o_v     (w_fifo_v),
    .o_data  (w_fifo_out),
    .i_yumi  (w_yumi),
    .o_count (w_fifo_cnt)
  );

  // Next state: IDLE -> SEND/DONE -> DONE -> IDLE.
  always_comb begin
    w_state_n = r_state;
    unique case (1'b1)
      (r_state == TX_IDLE):
        if (packet_send_i)
          w_state_n = (r_len == '0) ? TX_DONE : TX_SEND;
      (r_state == TX_SEND):
        if (w_yumi & tx_last_o) w_state_n = TX_DONE;
      default: w_state_n = TX_IDLE;
    endcase
  end

  // FSM, read pipeline and frame length.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= TX_IDLE;
      r_len       <= '0;
      r_rd_idx    <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_pend_keep <= 4'h0;
    end else begin
      r_state     <= w_state_n;
      r_pend      <= w_rd_v;
      r_pend_last <= w_rd_last;
      r_pend_keep <= w_rd_keep;
      if (w_rd_v) r_rd_idx <= w_rd_idx + bw_lp'(1);
      if (packet_wsize_valid_i & w_idle)
        r_len <= (packet_wsize_i > mtu_lp)
               ? mtu_lp : packet_wsize_i;
    end
  end

  // Event bits and write-drop pulse; a set beats a clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pending <= 1'b0;
      r_enable  <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      if (r_state == TX_DONE)    r_pending <= 1'b1;
      else if (tx_interrupt_clear_i) r_pending <= 1'b0;
      if (tx_interrupt_enable_v_i)
        r_enable <= tx_interrupt_enable_i;
      r_wr_err <= (packet_wvalid_i & ~w_wr_ok)
                | (packet_wsize_valid_i & ~w_idle);
    end
  end

  assign packet_req_o           = w_idle;
  assign tx_interrupt_pending_o = r_pending;
  assign tx_irq_o               = r_pending & r_enable;
  assign wr_error_o             = r_wr_err;
  assign tx_v_o                 = w_fifo_v;
  assign tx_last_o              = w_fifo_out[fw_lp-1];
  assign tx_keep_o = w_fifo_out[data_width_p +: 4];
  assign tx_data_o = w_fifo_out[data_width_p-1:0];

endmodule

// File: tb/tb_ethernet_tx_packet_buffer.sv
// Self-checking bench for ethernet_tx_packet_buffer:
// vector table, directed corner cases and random frames.
module tb_ethernet_tx_packet_buffer;

  localparam int MTU = 2048;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        packet_wvalid_i;
  logic [10:0] packet_waddr_i;
  logic [31:0] packet_wdata_i;
  logic [1:0]  packet_wdata_size_i;
  logic        packet_wsize_valid_i;
  logic [11:0] packet_wsize_i;
  logic        packet_send_i;
  logic        packet_req_o;
  logic        tx_interrupt_clear_i;
  logic        tx_interrupt_enable_i;
  logic        tx_interrupt_enable_v_i;
  logic        tx_interrupt_pending_o;
  logic        tx_irq_o;
  logic [31:0] tx_data_o;
  logic [3:0]  tx_keep_o;
  logic        tx_last_o;
  logic        tx_v_o;
  logic        tx_ready_and_i;
  logic        wr_error_o;

  always #5 clk_i = ~clk_i;

  ethernet_tx_packet_buffer #(
    .eth_mtu_p    (MTU),
    .data_width_p (32)
  ) dut (
    .clk_i                   (clk_i),
    .reset_n_i               (reset_n_i),
    .packet_wvalid_i         (packet_wvalid_i),
    .packet_waddr_i          (packet_waddr_i),
    .packet_wdata_i          (packet_wdata_i),
    .packet_wdata_size_i     (packet_wdata_size_i),
    .packet_wsize_valid_i    (packet_wsize_valid_i),
    .packet_wsize_i          (packet_wsize_i),
    .packet_send_i           (packet_send_i),
    .packet_req_o            (packet_req_o),
    .tx_interrupt_clear_i    (tx_interrupt_clear_i),
    .tx_interrupt_enable_i   (tx_interrupt_enable_i),
    .tx_interrupt_enable_v_i (tx_interrupt_enable_v_i),
    .tx_interrupt_pending_o  (tx_interrupt_pending_o),
    .tx_irq_o                (tx_irq_o),
    .tx_data_o               (tx_data_o),
    .tx_keep_o               (tx_keep_o),
    .tx_last_o               (tx_last_o),
    .tx_v_o                  (tx_v_o),
    .tx_ready_and_i          (tx_ready_and_i),
    .wr_error_o              (wr_error_o)
  );

  typedef struct {
    logic [10:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        exp_err;
  } wr_vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mdl_mem   [MTU];
  bit         mdl_known [MTU];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit mdl_legal(input int a,
                                   input int sz);
    if (sz > 2) return 1'b0;
    return (a % (1 << sz)) == 0;
  endfunction

  task automatic mdl_wr(input int a, input logic [31:0] d,
                        input int sz);
    for (int i = 0; i < (1 << sz); i++) begin
      mdl_mem[a+i]   = d[8*i +: 8];
      mdl_known[a+i] = 1'b1;
    end
  endtask

  task automatic wr(input logic [10:0] a,
                    input logic [31:0] d,
                    input logic [1:0] sz,
                    output logic err);
    packet_wvalid_i     = 1'b1;
    packet_waddr_i      = a;
    packet_wdata_i      = d;
    packet_wdata_size_i = sz;
    tick();
    packet_wvalid_i = 1'b0;
    err = wr_error_o;
  endtask

  task automatic setlen(input logic [11:0] v,
                        output logic err);
    packet_wsize_valid_i = 1'b1;
    packet_wsize_i       = v;
    tick();
    packet_wsize_valid_i = 1'b0;
    err = wr_error_o;
  endtask

  task automatic clear_pending();
    tx_interrupt_clear_i = 1'b1;
    tick();
    tx_interrupt_clear_i = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int k,
                            input int len);
    int nb, n;
    logic [3:0]  ek;
    logic [31:0] m, ed;
    nb = (len + 3) / 4;
    if (k >= nb) begin
      chk({tag, " extra beat"}, k, nb - 1);
      return;
    end
    n  = len - 4 * k;
    ek = (n >= 4) ? 4'hF : 4'((1 << n) - 1);
    chk({tag, " keep"}, {28'd0, tx_keep_o}, {28'd0, ek});
    chk({tag, " last"}, {31'd0, tx_last_o},
        {31'd0, (k == nb - 1)});
    m  = '0;
    ed = '0;
    for (int b = 0; b < 4; b++) begin
      if (ek[b] && mdl_known[4*k+b]) begin
        m[8*b +: 8]  = 8'hFF;
        ed[8*b +: 8] = mdl_mem[4*k+b];
      end
    end
    chk({tag, " data"}, tx_data_o & m, ed);
  endtask

  // mode 0: ready=1, 1: ready toggles 1010, 2: random.
  task automatic frame(input int len, input int mode,
                       input bit clr_done, input bit do_send,
                       input string tag);
    int nb, got, cyc, first_v, budget;
    bit done, stall;
    logic rdy;
    logic [36:0] held;
    nb = (len + 3) / 4;
    got = 0; cyc = 0; first_v = -1;
    done = 1'b0; stall = 1'b0; held = '0;
    budget = nb * 4 + 20;
    if (do_send) begin
      packet_send_i = 1'b1;
      tick();
      packet_send_i = 1'b0;
      cyc = 1;
    end
    while (!done && cyc < budget) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tx_ready_and_i = rdy;
      if (tx_v_o && first_v < 0) first_v = cyc;
      if (stall) begin
        chk({tag, " stall v"}, {31'd0, tx_v_o}, 32'd1);
        chk({tag, " stall hold"},
            {27'd0, tx_last_o, tx_keep_o} ^ held[36:32],
            32'd0);
        chk({tag, " stall data"}, tx_data_o, held[31:0]);
      end
      if (tx_v_o && rdy) begin
        check_beat(tag, got, len);
        if (tx_last_o) done = 1'b1;
        got++;
      end
      stall = tx_v_o && !rdy;
      held  = {tx_last_o, tx_keep_o, tx_data_o};
      tick();
      cyc++;
    end
    tx_ready_and_i = 1'b0;
    chk({tag, " finished"}, {31'd0, done}, 32'd1);
    chk({tag, " beats"}, got, nb);
    if (do_send)
      chk({tag, " latency<=2"},
          {31'd0, (first_v >= 0 && first_v <= 2)}, 32'd1);
    if (done) begin
      chk({tag, " req in done"}, {31'd0, packet_req_o}, 0);
      chk({tag, " v in done"}, {31'd0, tx_v_o}, 0);
      if (clr_done) clear_pending();
      else tick();
      chk({tag, " pending"},
          {31'd0, tx_interrupt_pending_o}, 32'd1);
      chk({tag, " req after"}, {31'd0, packet_req_o}, 1);
    end
  endtask

  wr_vec_t vt [12];
  logic err;

  initial begin
    vt[0]  = '{11'd1, 32'h000000AA, 2'd0, 1'b0};
    vt[1]  = '{11'd2, 32'h0000CCBB, 2'd1, 1'b0};
    vt[2]  = '{11'd1, 32'h0000DDEE, 2'd1, 1'b1};
    vt[3]  = '{11'd0, 32'h00000011, 2'd0, 1'b0};
    vt[4]  = '{11'd3, 32'h12345678, 2'd2, 1'b1};
    vt[5]  = '{11'd6, 32'h0000FFFF, 2'd1, 1'b0};
    vt[6]  = '{11'd5, 32'h00000099, 2'd0, 1'b0};
    vt[7]  = '{11'd4, 32'h00000055, 2'd0, 1'b0};
    vt[8]  = '{11'd7, 32'h00000077, 2'd0, 1'b0};
    vt[9]  = '{11'd2, 32'h0BADF00D, 2'd2, 1'b1};
    vt[10] = '{11'd8, 32'hA5A5A5A5, 2'd2, 1'b0};
    vt[11] = '{11'd0, 32'h01020304, 2'd3, 1'b1};

    reset_n_i = 1'b0;
    packet_wvalid_i = 1'b0; packet_waddr_i = '0;
    packet_wdata_i = '0; packet_wdata_size_i = '0;
    packet_wsize_valid_i = 1'b0; packet_wsize_i = '0;
    packet_send_i = 1'b0; tx_interrupt_clear_i = 1'b0;
    tx_interrupt_enable_i = 1'b0;
    tx_interrupt_enable_v_i = 1'b0;
    tx_ready_and_i = 1'b0;
    for (int i = 0; i < MTU; i++) mdl_known[i] = 1'b0;

    #22;
    chk("rst req", {31'd0, packet_req_o}, 32'd1);
    chk("rst v", {31'd0, tx_v_o}, 32'd0);
    chk("rst pend", {31'd0, tx_interrupt_pending_o}, 0);
    chk("rst irq", {31'd0, tx_irq_o}, 32'd0);
    chk("rst werr", {31'd0, wr_error_o}, 32'd0);
    @(negedge clk_i) reset_n_i = 1'b1;
    tick();

    for (int w = 0; w < MTU / 4; w++) begin
      logic [31:0] d;
      d = $urandom;
      wr(11'(4 * w), d, 2'd2, err);
      mdl_wr(4 * w, d, 2);
    end

    wr(11'd0, 32'h04030201, 2'd2, err);
    mdl_wr(0, 32'h04030201, 2);
    wr(11'd4, 32'h08070605, 2'd2, err);
    mdl_wr(4, 32'h08070605, 2);
    setlen(12'd6, err);
    chk("len6 werr", {31'd0, err}, 32'd0);
    frame(6, 0, 1'b0, 1'b1, "f6");
    clear_pending();
    frame(6, 1, 1'b0, 1'b1, "f6 toggle");

    for (int i = 0; i < 12; i++) begin
      wr(vt[i].addr, vt[i].data, vt[i].size, err);
      chk($sformatf("vec%0d werr", i), {31'd0, err},
          {31'd0, vt[i].exp_err});
      if (!vt[i].exp_err)
        mdl_wr(int'(vt[i].addr), vt[i].data,
               int'(vt[i].size));
      tick();
      chk($sformatf("vec%0d pulse", i),
          {31'd0, wr_error_o}, 32'd0);
    end
    setlen(12'd9, err);
    frame(9, 2, 1'b0, 1'b1, "lanes");

    clear_pending();
    setlen(12'd0, err);
    packet_send_i = 1'b1;
    tick();
    packet_send_i = 1'b0;
    chk("len0 v", {31'd0, tx_v_o}, 32'd0);
    chk("len0 req", {31'd0, packet_req_o}, 32'd0);
    chk("len0 pend early", {31'd0, tx_interrupt_pending_o}, 0);
    tick();
    chk("len0 pend", {31'd0, tx_interrupt_pending_o}, 1);
    chk("len0 v2", {31'd0, tx_v_o}, 32'd0);
    chk("irq disabled", {31'd0, tx_irq_o}, 32'd0);
    tx_interrupt_enable_i = 1'b1;
    tx_interrupt_enable_v_i = 1'b1;
    tick();
    tx_interrupt_enable_v_i = 1'b0;
    chk("irq enabled", {31'd0, tx_irq_o}, 32'd1);
    tx_interrupt_enable_i = 1'b0;
    tick();
    chk("enable no strobe", {31'd0, tx_irq_o}, 32'd1);
    clear_pending();
    chk("clr pend", {31'd0, tx_interrupt_pending_o}, 0);
    chk("clr irq", {31'd0, tx_irq_o}, 32'd0);

    setlen(12'd40, err);
    packet_send_i = 1'b1;
    tick();
    packet_send_i = 1'b0;
    chk("busy req", {31'd0, packet_req_o}, 32'd0);
    wr(11'd32, 32'hDEADBEEF, 2'd2, err);
    chk("busy wr err", {31'd0, err}, 32'd1);
    setlen(12'd8, err);
    chk("busy len err", {31'd0, err}, 32'd1);
    packet_send_i = 1'b1;
    tick();
    packet_send_i = 1'b0;
    chk("busy pend0", {31'd0, tx_interrupt_pending_o}, 0);
    frame(40, 0, 1'b1, 1'b0, "busy");

    setlen(12'd2049, err);
    frame(2048, 0, 1'b0, 1'b1, "clamp");

    for (int f = 0; f < 15; f++) begin
      int a, sz, len;
      logic [31:0] d;
      for (int j = 0; j < 12; j++) begin
        a  = $urandom_range(0, 63);
        sz = $urandom_range(0, 3);
        d  = $urandom;
        wr(11'(a), d, 2'(sz), err);
        chk($sformatf("rnd%0d wr%0d err", f, j),
            {31'd0, err}, {31'd0, !mdl_legal(a, sz)});
        if (mdl_legal(a, sz)) mdl_wr(a, d, sz);
      end
      len = $urandom_range(1, 64);
      setlen(12'(len), err);
      frame(len, 2, 1'($urandom_range(0, 1)), 1'b1,
            $sformatf("rnd%0d", f));
    end

    setlen(12'd2048, err);
    chk("pre-rst pend", {31'd0, tx_interrupt_pending_o}, 1);
    tx_ready_and_i = 1'b1;
    packet_send_i = 1'b1;
    tick();
    packet_send_i = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("mid stream v", {31'd0, tx_v_o}, 32'd1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("abort v", {31'd0, tx_v_o}, 32'd0);
    chk("abort req", {31'd0, packet_req_o}, 32'd1);
    chk("abort pend", {31'd0, tx_interrupt_pending_o}, 0);
    @(negedge clk_i) reset_n_i = 1'b1;
    tick();
    chk("post-rst v", {31'd0, tx_v_o}, 32'd0);
    packet_send_i = 1'b1;
    tick();
    packet_send_i = 1'b0;
    chk("post-rst len0 v", {31'd0, tx_v_o}, 32'd0);
    tick();
    chk("post-rst len0 pend",
        {31'd0, tx_interrupt_pending_o}, 32'd1);
    tx_ready_and_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
